uart_pkt_transmitter: RTL and testbench
=======================================

UART_PKT_TRANSMITTER -- requirements
Module: uart_pkt_transmitter

Interface
REQ-001 Parameter CLOCK, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115_200, line rate in bit/s.
REQ-003 Parameter PARITY, "NO", one of "NO"/"EVEN"/"ODD".
REQ-004 Parameter FIRST_BIT, "LSB", data bit order, "LSB" or "MSB".
REQ-005 Parameter NUMBER, 256, payload buffer depth in bytes; AW = clogb2(NUMBER).
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request to send one packet; sampled only when tx_busy=0.
REQ-009 cmd_tx  in  8  command byte, latched on accepted start.
REQ-010 len_tx  in  8  payload length in bytes, latched on accepted start.
REQ-011 rd_data  in  8  payload byte from synchronous buffer, valid 1 cycle after rd_addr.
REQ-012 rd_addr  out  AW  payload buffer read address.
REQ-013 rd_clock  out  1  buffer read clock, equal to clk.
REQ-014 txd  out  1  serial line, idle high.
REQ-015 tx_busy  out  1  high from start acceptance until packet end.
REQ-016 tx_done  out  1  one-cycle pulse at packet end.

Function
REQ-017 Packet on line SHALL be: cmd_tx, len_tx, then len_tx payload bytes read from rd_addr 0..len_tx-1; len_tx=0 sends header only.
REQ-018 Byte frame SHALL be: start bit 0, 8 data bits in FIRST_BIT order, parity bit if PARITY!="NO" (EVEN: XOR of data; ODD: inverted XOR), one stop bit 1.
REQ-019 Each bit SHALL last BIT_TICKS = CLOCK/BAUD (integer division) clk cycles.
REQ-020 Bytes SHALL be back-to-back: the next start bit begins in the cycle after the previous stop bit ends.
REQ-021 start high with tx_busy=0 at edge N SHALL latch cmd_tx/len_tx and drive tx_busy=1 and txd=0 from cycle N+1.
REQ-022 start while tx_busy=1 SHALL be ignored; input changes after acceptance SHALL NOT affect the packet.
REQ-023 States SHALL be IDLE, SEND_CMD, SEND_LEN, FETCH, SEND_DATA, DONE; IDLE->SEND_CMD on accepted start; SEND_CMD->SEND_LEN at stop end; SEND_LEN->DONE if len=0 else FETCH; FETCH->SEND_DATA; SEND_DATA->FETCH if bytes remain else DONE; DONE->IDLE after one cycle.
REQ-024 rd_addr for byte k SHALL be presented no later than the start of the stop bit of the preceding byte, so the 1-cycle read latency never stretches the line.
REQ-025 Payload index SHALL be 8 bits; rd_addr = index mod NUMBER (wraps if len_tx > NUMBER).
REQ-026 tx_done SHALL pulse for exactly one cycle, the cycle after the last stop bit ends; tx_busy SHALL be 0 in that cycle, and a start in that cycle SHALL be accepted.
REQ-027 txd SHALL be registered (glitch-free) and high whenever tx_busy=0.

Reset
REQ-028 reset SHALL override start in the same cycle and abort any packet, including mid-bit.
REQ-029 After reset: txd=1, tx_busy=0, tx_done=0, rd_addr=0, state IDLE, bit/tick counters 0.

Structure
REQ-030 Package uart_pkg SHALL hold clogb2 function, parity enum, tx state typedef and BIT_TICKS computation, shared with the receive side.
REQ-031 Byte serialisation SHALL live in sub-module SingleTxUART (ports clk, reset, tx_data, send, txd, done, busy), mirroring SingleRxUART.

Verification (CLOCK=16, BAUD=1, BIT_TICKS=16)
REQ-032 PARITY="NO", cmd=0xA5, len=0 -> 20 bits: 0,10100101,1 then 0,00000000,1 (LSB first); tx_done at cycle 321 after acceptance.
REQ-033 len=3, buffer {0x01,0x80,0xFF} -> rd_addr 0,1,2 in order; 5 contiguous frames, no idle gap; decoded bytes match.
REQ-034 PARITY="EVEN" cmd=0x07 -> parity 1; PARITY="ODD" cmd=0x07 -> parity 0; FIRST_BIT="MSB" cmd=0x01 -> data bits 00000001.
REQ-035 start pulsed again mid-packet with cmd=0x55 -> ignored; line carries only original packet.
REQ-036 reset asserted in payload byte 2 -> next cycle txd=1, tx_busy=0, no tx_done; fresh start then sends a complete packet.
REQ-037 start held high continuously -> packets back-to-back, new start bit in the tx_done cycle+1; len=255, NUMBER=16 -> rd_addr wraps 15->0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the packet transmit and receive sides.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_LEN,
        FETCH,
        SEND_DATA,
        DONE
    } tx_state_e;

    // Address width for a buffer of the given depth, never below one bit.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int bit_ticks(input int clock, input int baud);
        return clock / baud;
    endfunction

endpackage

// File: rtl/uart_pkt_transmitter_if.sv
// Host side of the packet transmitter: request, status and payload buffer port.
interface uart_pkt_transmitter_if #(
    parameter int AW = 8
);
    logic          start;
    logic [7:0]    cmd_tx;
    logic [7:0]    len_tx;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          tx_busy;
    logic          tx_done;

    modport master (
        output start, cmd_tx, len_tx, rd_data,
        input  rd_addr, tx_busy, tx_done
    );

    modport slave (
        input  start, cmd_tx, len_tx, rd_data,
        output rd_addr, tx_busy, tx_done
    );
endinterface

// File: rtl/SingleTxUART.sv
// Byte serialiser: start bit, 8 data bits, optional parity, one stop bit.
// done marks the last tick of the stop bit so the next byte follows gap-free.
module SingleTxUART
    import uart_pkg::*;
#(
    parameter int      BIT_TICKS = 434,
    parameter parity_e PAR       = PAR_NONE,
    parameter bit      MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       txd,
    output logic       done,
    output logic       busy
);
    localparam int TW = clogb2(BIT_TICKS + 1);
    localparam int NB = (PAR == PAR_NONE) ? 10 : 11;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(NB - 1);

    logic [TW-1:0] tick_q;
    logic [3:0]    bit_q;
    logic [9:0]    sh_q;
    logic          txd_q;
    logic          busy_q;
    logic [7:0]    ord;
    logic          par;
    logic [9:0]    frame;

    always_comb begin
        ord = tx_data;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) ord[i] = tx_data[7-i];
        end
        par = (PAR == PAR_ODD) ? ~(^tx_data) : ^tx_data;
        // Everything after the start bit, shifted out LSB first; ones fill behind.
        frame = (PAR == PAR_NONE) ? {2'b11, ord} : {1'b1, par, ord};
    end

    assign done = busy_q && (bit_q == BIT_LAST) && (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else if (send && (!busy_q || done)) begin
            tick_q <= '0;
            bit_q  <= '0;
            sh_q   <= frame;
            txd_q  <= 1'b0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (tick_q == TICK_LAST) begin
                tick_q <= '0;
                if (bit_q == BIT_LAST) begin
                    bit_q  <= '0;
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    txd_q <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[9:1]};
                end
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_pkt_transmitter.sv
// Packet transmitter: sends cmd, len, then len payload bytes from a sync buffer.
module uart_pkt_transmitter
    import uart_pkg::*;
#(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 115_200,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    NUMBER    = 256
) (
    input  logic clk,
    input  logic reset,
    uart_pkt_transmitter_if.slave bus,
    output logic rd_clock,
    output logic txd
);
    localparam int AW = clogb2(NUMBER);
    localparam int BT = bit_ticks(CLOCK, BAUD);
    localparam parity_e PAR = (PARITY == "EVEN") ? PAR_EVEN :
                              (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
    localparam bit MSB_FIRST = (FIRST_BIT == "MSB");

    tx_state_e     state_q;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [7:0]    idx_n;
    logic [AW-1:0] rd_addr_q;
    logic          busy_q;
    logic          done_q;
    logic          accept;
    logic          ser_send;
    logic          ser_done;
    logic          ser_busy;
    logic [7:0]    ser_data;

    assign accept = bus.start && !busy_q && !ser_busy;
    assign idx_n  = idx_q + 8'd1;

    // The next byte is launched in the stop bit's last tick to keep the line gap-free.
    always_comb begin
        ser_send = 1'b0;
        ser_data = bus.cmd_tx;
        unique case (state_q)
            IDLE, DONE: ser_send = accept;
            SEND_CMD: begin
                ser_send = ser_done;
                ser_data = len_q;
            end
            SEND_LEN: begin
                ser_send = ser_done && (len_q != 8'd0);
                ser_data = bus.rd_data;
            end
            SEND_DATA: begin
                ser_send = ser_done && (idx_q != len_q);
                ser_data = bus.rd_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (accept) begin
                        state_q   <= SEND_CMD;
                        len_q     <= bus.len_tx;
                        idx_q     <= '0;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SEND_CMD: if (ser_done) state_q <= SEND_LEN;
                SEND_LEN: begin
                    if (ser_done) begin
                        if (len_q == 8'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                // Address of the following byte goes out while this one is still on the line.
                FETCH: begin
                    idx_q     <= idx_n;
                    rd_addr_q <= AW'(int'(idx_n) % NUMBER);
                    state_q   <= SEND_DATA;
                end
                SEND_DATA: begin
                    if (ser_done) begin
                        if (idx_q != len_q) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    SingleTxUART #(
        .BIT_TICKS(BT),
        .PAR      (PAR),
        .MSB_FIRST(MSB_FIRST)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .tx_data(ser_data),
        .send   (ser_send),
        .txd    (txd),
        .done   (ser_done),
        .busy   (ser_busy)
    );

    assign rd_clock    = clk;
    assign bus.rd_addr = rd_addr_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_pkt_transmitter.sv
// Directed bench for uart_pkt_transmitter: three parity/order variants at 16 ticks per bit.
module tb_uart_pkt_transmitter;
    import uart_pkg::*;

    localparam int N  = 16;
    localparam int AW = clogb2(N);
    localparam int BT = 16;

    typedef struct {
        int         sel;
        logic [7:0] cmd;
        logic [7:0] len;
        int         nb;
        logic [10:0] bits;
        bit         poke;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [7:0] cmd;
    logic [7:0] len;
    int sel;
    int total = 0;
    int bad = 0;
    logic [7:0] mem [0:N-1];
    logic cap [0:255];
    logic txd0, txd1, txd2;
    logic rdclk0, rdclk1, rdclk2;
    logic line, busy, done;
    logic [AW-1:0] addr;

    always #5 clk = ~clk;

    uart_pkt_transmitter_if #(.AW(AW)) bus0 ();
    uart_pkt_transmitter_if #(.AW(AW)) bus1 ();
    uart_pkt_transmitter_if #(.AW(AW)) bus2 ();

    assign bus0.start  = start && (sel == 0);
    assign bus1.start  = start && (sel == 1);
    assign bus2.start  = start && (sel == 2);
    assign bus0.cmd_tx = cmd;
    assign bus1.cmd_tx = cmd;
    assign bus2.cmd_tx = cmd;
    assign bus0.len_tx = len;
    assign bus1.len_tx = len;
    assign bus2.len_tx = len;

    always @(posedge rdclk0) bus0.rd_data <= mem[bus0.rd_addr];
    always @(posedge rdclk1) bus1.rd_data <= mem[bus1.rd_addr];
    always @(posedge rdclk2) bus2.rd_data <= mem[bus2.rd_addr];

    uart_pkt_transmitter #(
        .CLOCK(16), .BAUD(1), .PARITY("NO"), .FIRST_BIT("LSB"), .NUMBER(N)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .rd_clock(rdclk0), .txd(txd0)
    );

    uart_pkt_transmitter #(
        .CLOCK(16), .BAUD(1), .PARITY("EVEN"), .FIRST_BIT("MSB"), .NUMBER(N)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .rd_clock(rdclk1), .txd(txd1)
    );

    uart_pkt_transmitter #(
        .CLOCK(16), .BAUD(1), .PARITY("ODD"), .FIRST_BIT("LSB"), .NUMBER(N)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .rd_clock(rdclk2), .txd(txd2)
    );

    always_comb begin
        line = txd0;
        busy = bus0.tx_busy;
        done = bus0.tx_done;
        addr = bus0.rd_addr;
        if (sel == 1) begin
            line = txd1;
            busy = bus1.tx_busy;
            done = bus1.tx_done;
            addr = bus1.rd_addr;
        end else if (sel == 2) begin
            line = txd2;
            busy = bus2.tx_busy;
            done = bus2.tx_done;
            addr = bus2.rd_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pkt(input vec_t v);
        int nf;
        int tot;
        int done_k;
        int npulse;
        int base;
        logic [7:0] d;
        logic [7:0] exp_b;
        logic exp_p;
        sel   = v.sel;
        cmd   = v.cmd;
        len   = v.len;
        start = 1'b1;
        tick();
        start  = 1'b0;
        nf     = 2 + int'(v.len);
        tot    = nf * v.nb * BT;
        done_k = -1;
        npulse = 0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_startbit", 32'(line), 32'd0);
        for (int k = 0; k <= tot + 2; k++) begin
            if (k > 0) tick();
            if (v.poke && k == 40) begin
                start = 1'b1;
                cmd   = 8'h55;
                len   = 8'd0;
            end
            if (v.poke && k == 44) start = 1'b0;
            if ((k % BT) == BT / 2 && (k / BT) < nf * v.nb) cap[k/BT] = line;
            if (done) begin
                npulse++;
                if (done_k < 0) done_k = k;
            end
            if (k == tot - 1) chk("busy_last_tick", 32'(busy), 32'd1);
            if (k == tot) begin
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("line_in_done", 32'(line), 32'd1);
            end
        end
        chk("done_cycle", 32'(done_k), 32'(tot));
        chk("done_pulses", 32'(npulse), 32'd1);
        for (int i = 0; i < v.nb; i++)
            chk("cmd_bit", 32'(cap[i]), 32'(v.bits[v.nb-1-i]));
        for (int f = 1; f < nf; f++) begin
            base  = f * v.nb;
            exp_b = (f == 1) ? v.len : mem[(f-2) % N];
            d     = '0;
            for (int j = 0; j < 8; j++) begin
                if (v.sel == 1) d[7-j] = cap[base+1+j];
                else            d[j]   = cap[base+1+j];
            end
            chk("frame_start", 32'(cap[base]), 32'd0);
            chk("frame_stop", 32'(cap[base+v.nb-1]), 32'd1);
            chk("frame_byte", 32'(d), 32'(exp_b));
            if (v.nb == 11) begin
                exp_p = (v.sel == 1) ? ^exp_b : ~(^exp_b);
                chk("frame_parity", 32'(cap[base+9]), 32'(exp_p));
            end
        end
    endtask

    vec_t vt [8];
    vec_t fresh;

    initial begin
        int k;
        int n;
        int got;
        logic [AW-1:0] seen [0:16];
        logic [AW-1:0] last;

        for (int i = 0; i < N; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h01;
        mem[1] = 8'h80;
        mem[2] = 8'hFF;

        vt[0] = '{0, 8'hA5, 8'd0, 10, 11'b0101001011, 1'b0};
        vt[1] = '{0, 8'h3C, 8'd3, 10, 11'b0001111001, 1'b0};
        vt[2] = '{1, 8'h07, 8'd0, 11, 11'b00000011111, 1'b0};
        vt[3] = '{1, 8'h01, 8'd1, 11, 11'b00000000111, 1'b0};
        vt[4] = '{2, 8'h07, 8'd2, 11, 11'b01110000001, 1'b0};
        vt[5] = '{2, 8'h00, 8'd0, 11, 11'b00000000011, 1'b0};
        vt[6] = '{0, 8'hFF, 8'd1, 10, 11'b0111111111, 1'b0};
        vt[7] = '{0, 8'h12, 8'd1, 10, 11'b0010010001, 1'b1};
        fresh = '{0, 8'h5A, 8'd2, 10, 11'b0010110101, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        cmd   = '0;
        len   = '0;
        sel   = 0;
        repeat (3) tick();
        chk("rst_txd0", 32'(txd0), 32'd1);
        chk("rst_txd1", 32'(txd1), 32'd1);
        chk("rst_txd2", 32'(txd2), 32'd1);
        chk("rst_busy", 32'(bus0.tx_busy), 32'd0);
        chk("rst_done", 32'(bus0.tx_done), 32'd0);
        chk("rst_addr", 32'(bus0.rd_addr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) begin
            run_pkt(vt[i]);
            repeat (3) tick();
        end

        // Reset in the middle of the second payload byte, with start also high.
        sel   = 0;
        cmd   = 8'h44;
        len   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (530) tick();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_txd", 32'(line), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        got   = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done || !line) got++;
        end
        chk("abort_quiet", 32'(got), 32'd0);
        run_pkt(fresh);
        repeat (3) tick();

        // start held: the next packet begins right after the tx_done cycle.
        sel   = 0;
        cmd   = 8'h81;
        len   = 8'd0;
        start = 1'b1;
        tick();
        repeat (320) tick();
        chk("held_done", 32'(done), 32'd1);
        chk("held_busy_low", 32'(busy), 32'd0);
        chk("held_idle_line", 32'(line), 32'd1);
        tick();
        chk("held_restart_line", 32'(line), 32'd0);
        chk("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        got   = -1;
        for (k = 322; k < 700 && got < 0; k++) begin
            tick();
            if (done) got = k;
        end
        chk("held_second_done", 32'(got), 32'd641);
        repeat (3) tick();

        // len=255 on a 16-entry buffer: address must wrap 15 -> 0.
        sel   = 0;
        cmd   = 8'h00;
        len   = 8'd255;
        start = 1'b1;
        tick();
        start   = 1'b0;
        n       = 1;
        seen[0] = addr;
        last    = addr;
        for (int i = 0; i < 17 * 160 + 320 && n < 17; i++) begin
            tick();
            if (addr != last) begin
                seen[n] = addr;
                n++;
                last = addr;
            end
        end
        chk("wrap_count", 32'(n), 32'd17);
        for (int i = 0; i < n; i++)
            chk("wrap_addr", 32'(seen[i]), 32'(i % N));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
